// File: rtl/huff_encoder.sv
// Table-driven Huffman encoder: looks up per-symbol length/code in shared memory
// and packs code bits MSB-first into bytes with a valid/ready output stream.
module huff_encoder (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enc_start,
  output logic        busy,
  output logic        enc_done,
  output logic        err,
  input  logic        sym_valid,
  input  logic [6:0]  sym_data,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic [15:0] mem_addr,
  output logic        mem_R,
  input  logic [7:0]  mem_data_R,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [15:0] bit_total
);

  typedef enum logic [3:0] {
    IDLE, ACCEPT, RD_LEN, WAIT_LEN, RD_CODE, WAIT_CODE,
    SHIFT, EMIT, FLUSH, FLUSH_EMIT, DONE
  } state_t;

  state_t      state;
  logic [6:0]  sym;
  logic        last;
  logic [3:0]  len;
  logic [7:0]  code;
  logic [3:0]  remaining;
  logic [7:0]  acc;
  logic [3:0]  fill;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      sym       <= '0;
      last      <= 1'b0;
      len       <= '0;
      code      <= '0;
      remaining <= '0;
      acc       <= '0;
      fill      <= '0;
      err       <= 1'b0;
      bit_total <= '0;
    end else begin
      case (state)
        IDLE: if (enc_start) begin
          state     <= ACCEPT;
          bit_total <= '0;
          acc       <= '0;
          fill      <= '0;
          err       <= 1'b0;
        end
        ACCEPT: if (sym_valid) begin
          sym   <= sym_data;
          last  <= sym_last;
          state <= RD_LEN;
        end
        RD_LEN: state <= WAIT_LEN;
        WAIT_LEN: begin
          len <= mem_data_R[3:0];
          if (mem_data_R >= 8'd1 && mem_data_R <= 8'd8) begin
            state <= RD_CODE;
          end else begin
            err   <= 1'b1;
            state <= last ? FLUSH : ACCEPT;
          end
        end
        RD_CODE: state <= WAIT_CODE;
        WAIT_CODE: begin
          code      <= mem_data_R;
          remaining <= len;
          state     <= SHIFT;
        end
        SHIFT: begin
          acc       <= {acc[6:0], code[7]};
          code      <= {code[6:0], 1'b0};
          fill      <= fill + 4'd1;
          remaining <= remaining - 4'd1;
          bit_total <= bit_total + 16'd1;
          // Decide on the post-shift values: a full byte wins over end-of-code.
          if (fill + 4'd1 == 4'd8)
            state <= EMIT;
          else if (remaining - 4'd1 == 4'd0)
            state <= last ? FLUSH : ACCEPT;
        end
        EMIT: if (out_ready) begin
          fill <= '0;
          if (remaining != 4'd0)
            state <= SHIFT;
          else
            state <= last ? FLUSH : ACCEPT;
        end
        FLUSH: begin
          if (fill != 4'd0) begin
            acc   <= acc << (4'd8 - fill);
            state <= FLUSH_EMIT;
          end else begin
            state <= DONE;
          end
        end
        FLUSH_EMIT: if (out_ready) begin
          fill  <= '0;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    sym_ready = (state == ACCEPT);
    enc_done  = (state == DONE);
    out_valid = (state == EMIT) || (state == FLUSH_EMIT);
    out_data  = out_valid ? acc : '0;
    mem_R     = 1'b0;
    mem_addr  = '0;
    case (state)
      RD_LEN, WAIT_LEN: begin
        mem_R    = 1'b1;
        mem_addr = {9'd0, sym};
      end
      RD_CODE, WAIT_CODE: begin
        mem_R    = 1'b1;
        mem_addr = {8'd0, 1'b1, sym};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_huff_encoder.sv
// Scoreboard bench for huff_encoder: expected bytes queued per message, popped on handshake.
module tb_huff_encoder;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        enc_start = 1'b0;
  logic        busy, enc_done, err, sym_ready, mem_R, out_valid;
  logic        sym_valid = 1'b0;
  logic [6:0]  sym_data = '0;
  logic        sym_last = 1'b0;
  logic [15:0] mem_addr, bit_total;
  logic [7:0]  mem_data_R = '0;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int rd_run = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic [7:0]  mem [256];
  logic [6:0]  acc_sym = '0;
  logic [15:0] rd_addr = '0;
  logic [15:0] prev_addr = '0;
  logic [15:0] exp_a;

  huff_encoder dut (
    .clk(clk), .n_rst(n_rst), .enc_start(enc_start), .busy(busy),
    .enc_done(enc_done), .err(err), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_last(sym_last), .sym_ready(sym_ready), .mem_addr(mem_addr),
    .mem_R(mem_R), .mem_data_R(mem_data_R), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .bit_total(bit_total)
  );

  always #5 clk = ~clk;

  // Registered memory: data for an address appears one cycle after it is presented
  always @(posedge clk) mem_data_R <= mem[mem_addr[7:0]];

  always @(negedge clk) begin
    if (!n_rst) begin
      rd_run = 0;
    end else begin
      if (enc_done) done_cnt++;
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL out_byte: got %b, expected no byte", out_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (out_data !== exp_b) begin
            mismatched++;
            $display("FAIL out_byte: got %b, expected %b", out_data, exp_b);
          end
        end
      end
      if (mem_R && (rd_run == 0 || mem_addr == rd_addr)) begin
        if (rd_run == 0) rd_addr = mem_addr;
        rd_run++;
      end else begin
        if (rd_run > 0) begin
          compared++;
          exp_a = rd_addr[7] ? {8'd0, 1'b1, acc_sym} : {9'd0, acc_sym};
          if (rd_run != 2 || rd_addr !== exp_a ||
              (rd_addr[7] && prev_addr !== {9'd0, acc_sym}) ||
              (!mem_R && mem_addr !== 16'd0)) begin
            mismatched++;
            $display("FAIL mem_read: addr %0d held %0d cycles (idle addr %0d), expected addr %0d held 2 cycles",
                     rd_addr, rd_run, mem_addr, exp_a);
          end
          prev_addr = rd_addr;
        end
        if (mem_R) begin
          rd_addr = mem_addr;
          rd_run  = 1;
        end else begin
          rd_run = 0;
        end
      end
      if (sym_valid && sym_ready) acc_sym = sym_data;
    end
  end

  task automatic start_enc;
    @(posedge clk); #1 enc_start = 1'b1;
    @(posedge clk); #1 enc_start = 1'b0;
  endtask

  task automatic send_sym(input logic [6:0] s, input logic l);
    bit got = 0;
    @(posedge clk); #1;
    sym_valid = 1'b1; sym_data = s; sym_last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sym_ready) begin got = 1; break; end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL sym_accept: sym_ready=%b after 200 cycles, expected 1", sym_ready);
    end
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0;
  endtask

  task automatic wait_done;
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (enc_done) begin got = 1; break; end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL enc_done_wait: enc_done=%b after 400 cycles, expected 1", enc_done);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, enc_done, err, sym_ready, out_valid, mem_R, out_data, mem_addr, bit_total} !== 46'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got busy=%b err=%b out_data=%h mem_addr=%h bit_total=%0d, expected all 0",
               busy, err, out_data, mem_addr, bit_total);
    end
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, enc_done, err, sym_ready, out_valid, mem_R, out_data, mem_addr, bit_total} !== 46'd0) begin
        mismatched++;
        $display("FAIL post_reset_quiet: busy=%b sym_ready=%b mem_R=%b, expected all 0", busy, sym_ready, mem_R);
      end
    end
  endtask

  task automatic test_two_sym;
    int d0 = done_cnt;
    exp_q.push_back(8'b11010000);
    start_enc;
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_after_start: got %b, expected 1", busy);
    end
    send_sym(7'd6, 1'b0);
    send_sym(7'd1, 1'b1);
    wait_done;
    repeat (4) @(negedge clk);
    compared++;
    if (bit_total !== 16'd4 || busy !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL two_sym_end: bit_total=%0d busy=%b err=%b, expected 4 0 0", bit_total, busy, err);
    end
    compared++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL two_sym_done: done pulses=%0d pending bytes=%0d, expected 1 and 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_four_sym;
    exp_q.push_back(8'b10111010);
    exp_q.push_back(8'b10011000);
    start_enc;
    send_sym(7'd2, 1'b0);
    start_enc;
    send_sym(7'd3, 1'b0);
    send_sym(7'd5, 1'b0);
    send_sym(7'd6, 1'b1);
    wait_done;
    repeat (3) @(negedge clk);
    compared++;
    if (bit_total !== 16'd13 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL four_sym_end: bit_total=%0d pending=%0d, expected 13 and 0", bit_total, exp_q.size());
    end
  endtask

  task automatic test_back_to_back_stall;
    bit got = 0;
    out_ready = 1'b0;
    exp_q.push_back(8'b10111011);
    start_enc;
    send_sym(7'd2, 1'b0);
    send_sym(7'd2, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL stall_valid_wait: out_valid=%b after 100 cycles, expected 1", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      compared++;
      if ({out_valid, out_data} !== {1'b1, 8'b10111011}) begin
        mismatched++;
        $display("FAIL stall_hold: out_valid=%b out_data=%b, expected 1 10111011", out_valid, out_data);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done;
    repeat (3) @(negedge clk);
    compared++;
    if (bit_total !== 16'd8 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL stall_end: bit_total=%0d pending=%0d, expected 8 and 0", bit_total, exp_q.size());
    end
  endtask

  task automatic test_bad_len;
    exp_q.push_back(8'b00000000);
    start_enc;
    send_sym(7'd10, 1'b0);
    repeat (3) @(negedge clk);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_len_err: got %b, expected 1", err);
    end
    send_sym(7'd4, 1'b1);
    wait_done;
    repeat (3) @(negedge clk);
    compared++;
    if (bit_total !== 16'd2 || err !== 1'b1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL bad_len_end: bit_total=%0d err=%b pending=%0d, expected 2 1 0", bit_total, err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit got = 0;
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_sticky_idle: got %b, expected 1", err);
    end
    start_enc;
    @(negedge clk);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_clear_on_start: got %b, expected 0", err);
    end
    send_sym(7'd10, 1'b0);
    send_sym(7'd2, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_R && mem_addr == 16'd130) begin got = 1; break; end
    end
    for (int i = 0; i < 10; i++) begin
      if (!mem_R) break;
      @(negedge clk);
    end
    @(negedge clk);
    compared++;
    if (!got || bit_total !== 16'd1 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_shift_state: code read seen=%0d bit_total=%0d err=%b, expected 1 1 1", got, bit_total, err);
    end
    n_rst = 1'b0;
    #1;
    compared++;
    if ({busy, enc_done, err, sym_ready, out_valid, mem_R, out_data, mem_addr, bit_total} !== 46'd0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: busy=%b err=%b bit_total=%0d out_data=%h, expected all 0",
               busy, err, bit_total, out_data);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    exp_q.push_back(8'b11000000);
    start_enc;
    send_sym(7'd6, 1'b1);
    wait_done;
    repeat (3) @(negedge clk);
    compared++;
    if (err !== 1'b0 || bit_total !== 16'd2 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL after_reset_msg: err=%b bit_total=%0d pending=%0d, expected 0 2 0", err, bit_total, exp_q.size());
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'd0;
    mem[1] = 8'd2; mem[129] = 8'b01000000;
    mem[2] = 8'd4; mem[130] = 8'b10110000;
    mem[3] = 8'd4; mem[131] = 8'b10100000;
    mem[4] = 8'd2; mem[132] = 8'b00000000;
    mem[5] = 8'd3; mem[133] = 8'b10000000;
    mem[6] = 8'd2; mem[134] = 8'b11000000;
    test_reset;
    test_two_sym;
    test_four_sym;
    test_back_to_back_stall;
    test_bad_len;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
